sll_multicycle: RTL and testbench

Multicycle logical left shifter for the CPU ALU, the left-direction counterpart of the single-cycle arithmetic right shifter. It shifts one 32-bit operand left by 0–31 bits, zero-filling from the LSB. It resolves one bit of the shift amount per clock (16, 8, 4, 2, 1), so latency is a fixed five cycles. It connects to the ALU issue logic through a valid/ready handshake on input and output, and reports whether any 1 bits were shifted out.

---
 rtl/sll_multicycle_if.sv | 24 ++
 rtl/sll_multicycle.sv | 129 ++++++++++++
 tb/tb_sll_multicycle.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sll_multicycle_if.sv
// Handshake bundle between the ALU issue logic and the multicycle left shifter.
interface sll_multicycle_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [4:0]  amount;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        lost;
    logic        busy;

    // Shifter side
    modport slave (
        input  in_valid, A, amount, out_ready,
        output in_ready, out_valid, result, lost, busy
    );

    // Issue-logic side
    modport master (
        output in_valid, A, amount, out_ready,
        input  in_ready, out_valid, result, lost, busy
    );
endinterface

// File: rtl/sll_multicycle.sv
// Multicycle logical left shifter: resolves one shift-amount bit per clock
// (weights 16, 8, 4, 2, 1), fixed five-cycle latency, reports lost 1 bits.
module sll_multicycle (
    input  logic              clock,
    input  logic              reset,
    sll_multicycle_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic [4:0]  amt_q;
    logic [2:0]  step_q;
    logic        lost_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    logic        step_bit;
    logic [31:0] step_data;
    logic        step_lost;
    logic [31:0] data_d;
    logic        lost_d;

    // One shift step: pick the amount bit and shifted value for the current weight
    always_comb begin
        step_bit  = 1'b0;
        step_data = data_q;
        step_lost = 1'b0;
        case (step_q)
            3'd0: begin
                step_bit  = amt_q[4];
                step_data = {data_q[15:0], 16'b0};
                step_lost = |data_q[31:16];
            end
            3'd1: begin
                step_bit  = amt_q[3];
                step_data = {data_q[23:0], 8'b0};
                step_lost = |data_q[31:24];
            end
            3'd2: begin
                step_bit  = amt_q[2];
                step_data = {data_q[27:0], 4'b0};
                step_lost = |data_q[31:28];
            end
            3'd3: begin
                step_bit  = amt_q[1];
                step_data = {data_q[29:0], 2'b0};
                step_lost = |data_q[31:30];
            end
            3'd4: begin
                step_bit  = amt_q[0];
                step_data = {data_q[30:0], 1'b0};
                step_lost = data_q[31];
            end
            default: begin
                step_bit  = 1'b0;
                step_data = data_q;
                step_lost = 1'b0;
            end
        endcase
        data_d = step_bit ? step_data : data_q;
        lost_d = lost_q | (step_bit & step_lost);
    end

    // Control FSM with registered handshake outputs; no early exit for amount=0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_q      <= 32'h0;
            amt_q       <= 5'd0;
            step_q      <= 3'd0;
            lost_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.A;
                        amt_q      <= bus.amount;
                        step_q     <= 3'd0;
                        lost_q     <= 1'b0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    lost_q <= lost_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd4) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Input offers are ignored here; only the output handshake matters
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = data_q;
    assign bus.lost      = lost_q;

endmodule

// File: tb/tb_sll_multicycle.sv
// Scoreboard bench for sll_multicycle: directed corner cases plus random traffic.
module tb_sll_multicycle;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sll_multicycle_if bus ();

    sll_multicycle dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        lost;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rdy_rand = 1'b0;
    bit   prev_valid = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic shift, upper half holds the shifted-out bits
    function automatic exp_t model(input logic [31:0] a, input logic [4:0] amt, input int acc);
        logic [63:0] wide;
        exp_t e;
        wide   = {32'b0, a} << amt;
        e.res  = wide[31:0];
        e.lost = |wide[63:32];
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: compare every cycle output is presented, pop on handshake
    always @(negedge clock) begin
        if (reset && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", bus.result);
            end else begin
                chk("result", bus.result, sb[0].res);
                chk("lost", {31'b0, bus.lost}, {31'b0, sb[0].lost});
                if (!prev_valid)
                    chk("latency", cyc - sb[0].acc, 32'd5);
                if (bus.out_ready)
                    void'(sb.pop_front());
            end
        end
        prev_valid = bus.out_valid;
    end

    // Random consumer stalls when enabled
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Caller is aligned #1 after a rising edge
    task automatic issue(input logic [31:0] a, input logic [4:0] amt);
        int n;
        n = 0;
        while (!bus.in_ready) begin
            @(posedge clock);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready stayed %b, required 1", bus.in_ready);
                return;
            end
        end
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.amount   = amt;
        @(posedge clock);
        #1;
        sb.push_back(model(a, amt, cyc));
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.amount   = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 || !bus.in_ready) begin
            @(posedge clock);
            #1;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
                sb.delete();
                return;
            end
        end
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.A         = 32'h0;
        bus.amount    = 5'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_lost", {31'b0, bus.lost}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed cases
        bus.out_ready = 1'b1;
        issue(32'h00000001, 5'd31);
        drain();
        issue(32'hFFFFFFFF, 5'd4);
        drain();
        issue(32'h0FFFFFFF, 5'd4);
        drain();

        // Zero shift still takes five busy cycles
        issue(32'hDEADBEEF, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk("zero_busy", {31'b0, bus.busy}, 32'd1);
            chk("zero_no_valid", {31'b0, bus.out_valid}, 32'd0);
            @(posedge clock);
            #1;
        end
        chk("zero_valid_after5", {31'b0, bus.out_valid}, 32'd1);
        drain();

        // Backpressure with an ignored input offer during SHIFT/DONE
        bus.out_ready = 1'b0;
        issue(32'hA5A5A5A5, 5'd7);
        bus.in_valid = 1'b1;
        bus.A        = 32'h12345678;
        bus.amount   = 5'd3;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("bp_reached_done", {31'b0, bus.out_valid}, 32'd1);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("bp_no_accept", {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        issue(32'h12345678, 5'd3);
        chk("bp_single_pending", sb.size(), 32'd1);
        drain();

        // Reset two cycles after accept
        issue(32'h0000FFFF, 5'd16);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("mid_result", bus.result, 32'h0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        issue(32'h00000003, 5'd1);
        drain();

        // Random traffic with consumer stalls
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            issue($urandom, 5'($urandom_range(0, 31)));
        end
        drain();
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
